// File: rtl/apb_gpio_irq.sv
// APB GPIO port with 2-FF input synchroniser, per-pin debounce filter,
// OR/AND/XOR alias writes and sticky edge/level interrupts on one line.
module apb_gpio_irq #(
    parameter int          NBITS   = 8,
    parameter int          OEPOL   = 0,
    parameter int          DBW     = 8,
    parameter logic [31:0] OUT_RST = 32'h0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             apbi_psel,
    input  logic             apbi_penable,
    input  logic [31:0]      apbi_paddr,
    input  logic             apbi_pwrite,
    input  logic [31:0]      apbi_pwdata,
    output logic [31:0]      apbo_prdata,
    output logic             apbo_pirq,
    input  logic [NBITS-1:0] gpioi_din,
    output logic [NBITS-1:0] gpioo_dout,
    output logic [NBITS-1:0] gpioo_oen
);

    localparam logic [DBW-1:0] CNT_ONE = DBW'(1);
    localparam logic [DBW-1:0] CNT_MAX = '1;

    logic [NBITS-1:0] out_r, dir_r, imask_r, pol_r, edge_r, iflag_r;
    logic [DBW-1:0]   dbth_r;
    logic [NBITS-1:0] sync1, sync2, filt, filt_d;
    logic [DBW-1:0]   cnt [NBITS];

    logic             wr_en;
    logic [5:0]       reg_addr;
    logic [NBITS-1:0] wdat;
    logic [NBITS-1:0] w1c;
    logic [NBITS-1:0] ev;
    logic             dbth_wr;
    logic [DBW-1:0]   dbth_m1;
    logic             unused_bits;

    // APB handshake: a write commits on the cycle psel & penable & pwrite are
    // all high. There are no wait states (pready is implicitly 1) and prdata
    // is a pure function of paddr, so it is valid throughout the access phase.
    assign wr_en    = apbi_psel & apbi_penable & apbi_pwrite;
    assign reg_addr = apbi_paddr[7:2];
    assign wdat     = apbi_pwdata[NBITS-1:0];
    assign dbth_wr  = wr_en && (reg_addr == 6'h07);
    assign w1c      = (wr_en && (reg_addr == 6'h06)) ? wdat : '0;
    assign dbth_m1  = dbth_r - CNT_ONE;

    assign unused_bits = ^{apbi_paddr[31:8], apbi_paddr[1:0], apbi_pwdata};

    assign gpioo_dout = out_r;
    assign gpioo_oen  = (OEPOL != 0) ? dir_r : ~dir_r;

    // Edge mode looks for a transition towards POL; level mode fires every
    // cycle the filtered pin equals POL.
    assign ev = (edge_r & ((pol_r & filt & ~filt_d) | (~pol_r & ~filt & filt_d)))
              | (~edge_r & ~(filt ^ pol_r));

    always_ff @(posedge clk) begin
        if (rst) begin
            out_r     <= OUT_RST[NBITS-1:0];
            dir_r     <= '0;
            imask_r   <= '0;
            pol_r     <= '0;
            edge_r    <= '0;
            iflag_r   <= '0;
            dbth_r    <= '0;
            apbo_pirq <= 1'b0;
        end else begin
            if (wr_en) begin
                case (reg_addr)
                    6'h01: out_r   <= wdat;
                    6'h15: out_r   <= out_r | wdat;
                    6'h19: out_r   <= out_r & wdat;
                    6'h1D: out_r   <= out_r ^ wdat;
                    6'h02: dir_r   <= wdat;
                    6'h16: dir_r   <= dir_r | wdat;
                    6'h1A: dir_r   <= dir_r & wdat;
                    6'h1E: dir_r   <= dir_r ^ wdat;
                    6'h03: imask_r <= wdat;
                    6'h17: imask_r <= imask_r | wdat;
                    6'h1B: imask_r <= imask_r & wdat;
                    6'h1F: imask_r <= imask_r ^ wdat;
                    6'h04: pol_r   <= wdat;
                    6'h05: edge_r  <= wdat;
                    6'h07: dbth_r  <= apbi_pwdata[DBW-1:0];
                    default: ;
                endcase
            end
            // A new event outranks a write-1-to-clear in the same cycle.
            iflag_r   <= (iflag_r & ~w1c) | (ev & imask_r);
            apbo_pirq <= |iflag_r;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= '0;
            sync2  <= '0;
            filt   <= '0;
            filt_d <= '0;
            for (int i = 0; i < NBITS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1  <= gpioi_din;
            sync2  <= sync1;
            filt_d <= filt;
            for (int i = 0; i < NBITS; i++) begin
                if (dbth_r == '0) begin
                    filt[i] <= sync2[i];
                    cnt[i]  <= '0;
                end else if (sync2[i] == filt[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == dbth_m1) begin
                    filt[i] <= sync2[i];
                    cnt[i]  <= '0;
                end else if (cnt[i] != CNT_MAX) begin
                    cnt[i] <= cnt[i] + CNT_ONE;
                end
                // Changing the threshold restarts every pin's qualification.
                if (dbth_wr) begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    always_comb begin
        apbo_prdata = '0;
        case (reg_addr)
            6'h00:                      apbo_prdata[NBITS-1:0] = filt;
            6'h01, 6'h15, 6'h19, 6'h1D: apbo_prdata[NBITS-1:0] = out_r;
            6'h02, 6'h16, 6'h1A, 6'h1E: apbo_prdata[NBITS-1:0] = dir_r;
            6'h03, 6'h17, 6'h1B, 6'h1F: apbo_prdata[NBITS-1:0] = imask_r;
            6'h04:                      apbo_prdata[NBITS-1:0] = pol_r;
            6'h05:                      apbo_prdata[NBITS-1:0] = edge_r;
            6'h06:                      apbo_prdata[NBITS-1:0] = iflag_r;
            6'h07:                      apbo_prdata[DBW-1:0]   = dbth_r;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_apb_gpio_irq.sv
// Bench for apb_gpio_irq: register/alias vector table, hand-timed debounce and
// interrupt sequences, and random pin traffic against a sliding-window model.
module tb_apb_gpio_irq;

    logic        clk = 1'b0;
    logic        rst;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata, prdata;
    logic        pirq;
    logic [7:0]  din, dout, oen;

    int checks   = 0;
    int failures = 0;

    apb_gpio_irq #(.NBITS(8), .OEPOL(0), .DBW(8), .OUT_RST(32'h0)) dut (
        .clk(clk), .rst(rst),
        .apbi_psel(psel), .apbi_penable(penable), .apbi_paddr(paddr),
        .apbi_pwrite(pwrite), .apbi_pwdata(pwdata),
        .apbo_prdata(prdata), .apbo_pirq(pirq),
        .gpioi_din(din), .gpioo_dout(dout), .gpioo_oen(oen)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model state ----------------
    logic       model_on = 1'b0;
    logic [7:0] m_dbth, m_pol, m_edge, m_mask;
    logic [7:0] m_filt, m_filt_d, m_iflag, nf, ev, hv;
    logic       m_pirq, qualified;
    logic [7:0] hist[$];
    logic [8:0] exp_q[$];

    // Pin i adopts a new level once the synchronised input (din two edges
    // earlier) has disagreed with the filtered value for DBTH straight samples.
    always @(posedge clk) begin
        if (model_on) begin
            for (int i = 0; i < 8; i++) begin
                if (m_dbth == 8'd0) begin
                    hv = hist[hist.size()-2];
                    nf[i] = hv[i];
                end else begin
                    qualified = 1'b1;
                    for (int j = 0; j < int'(m_dbth); j++) begin
                        hv = hist[hist.size()-2-j];
                        if (hv[i] == m_filt[i]) qualified = 1'b0;
                    end
                    nf[i] = qualified ? ~m_filt[i] : m_filt[i];
                end
                if (m_edge[i])
                    ev[i] = m_pol[i] ? (m_filt[i] && !m_filt_d[i]) : (!m_filt[i] && m_filt_d[i]);
                else
                    ev[i] = (m_filt[i] == m_pol[i]);
            end
            m_pirq   = |m_iflag;
            m_iflag  = m_iflag | (ev & m_mask);
            m_filt_d = m_filt;
            m_filt   = nf;
            hist.push_back(din);
            if (hist.size() > 40) void'(hist.pop_front());
            exp_q.push_back({m_pirq, m_filt});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    // Combinational read: no clock edge is consumed.
    task automatic peek(input logic [31:0] a, output logic [31:0] d);
        psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = a;
        #1;
        d = prdata;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic run_random(input logic [7:0] dbth, input int ncyc);
        logic [7:0] pol, edg, msk;
        logic [8:0] e;
        @(negedge clk);
        rst = 1'b1; din = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        pol = 8'($urandom); edg = 8'($urandom); msk = 8'($urandom);
        apb_write(32'h1C, 32'(dbth));
        apb_write(32'h10, 32'(pol));
        apb_write(32'h14, 32'(edg));
        apb_write(32'h0C, 32'(msk));
        apb_write(32'h18, 32'hFF);
        m_dbth = dbth; m_pol = pol; m_edge = edg; m_mask = msk;
        m_filt = 8'h00; m_filt_d = 8'h00; m_pirq = 1'b0;
        m_iflag = msk & ~edg & ~pol;
        hist.delete();
        repeat (16) hist.push_back(8'h00);
        exp_q.delete();
        model_on = 1'b1;
        psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 32'h00;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL rnd_queue: got empty expected queue at cycle %0d", c);
            end else begin
                e = exp_q.pop_front();
                check("rnd_data", 32'(prdata[7:0]), 32'(e[7:0]));
                check("rnd_pirq", 32'(pirq), 32'(e[8]));
            end
            if ($urandom_range(0, 2) == 0) din = 8'($urandom);
        end
        model_on = 1'b0;
        psel = 1'b0; penable = 1'b0;
    endtask

    // ---------------- register vector table ----------------
    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [7:0]  exp_out;
        logic [7:0]  exp_dir;
        logic [7:0]  exp_imask;
        logic [7:0]  exp_rd;
    } vec_t;

    vec_t vecs[13];

    initial begin
        logic [31:0] rd;
        logic [7:0]  exp_oen;

        vecs[0]  = '{32'h04, 32'hF0, 8'hF0, 8'hFF, 8'h00, 8'hF0};
        vecs[1]  = '{32'h54, 32'h0F, 8'hFF, 8'hFF, 8'h00, 8'hFF};
        vecs[2]  = '{32'h64, 32'h3C, 8'h3C, 8'hFF, 8'h00, 8'h3C};
        vecs[3]  = '{32'h74, 32'hFF, 8'hC3, 8'hFF, 8'h00, 8'hC3};
        vecs[4]  = '{32'h40, 32'hFF, 8'hC3, 8'hFF, 8'h00, 8'h00};
        vecs[5]  = '{32'h08, 32'h0F, 8'hC3, 8'h0F, 8'h00, 8'h0F};
        vecs[6]  = '{32'h58, 32'h30, 8'hC3, 8'h3F, 8'h00, 8'h3F};
        vecs[7]  = '{32'h68, 32'hF1, 8'hC3, 8'h31, 8'h00, 8'h31};
        vecs[8]  = '{32'h78, 32'hFF, 8'hC3, 8'hCE, 8'h00, 8'hCE};
        vecs[9]  = '{32'h0C, 32'h81, 8'hC3, 8'hCE, 8'h81, 8'h81};
        vecs[10] = '{32'h5C, 32'h42, 8'hC3, 8'hCE, 8'hC3, 8'hC3};
        vecs[11] = '{32'h6C, 32'h0F, 8'hC3, 8'hCE, 8'h03, 8'h03};
        vecs[12] = '{32'h7C, 32'h05, 8'hC3, 8'hCE, 8'h06, 8'h06};

        // ---- clock / reset ----
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        din = 8'h00; rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_dout", 32'(dout), 32'h00);
        check("rst_oen", 32'(oen), 32'hFF);
        check("rst_pirq", 32'(pirq), 32'h0);
        peek(32'h18, rd); check("rst_iflag", rd, 32'h00);
        peek(32'h1C, rd); check("rst_dbth", rd, 32'h00);
        peek(32'h08, rd); check("rst_dir", rd, 32'h00);

        // ---- output register sweep ----
        apb_write(32'h08, 32'hFF);
        check("oen_dir_ff", 32'(oen), 32'h00);
        for (int v = 0; v < 256; v++) begin
            apb_write(32'h04, 32'(v));
            check("out_sweep", 32'(dout), 32'(v));
        end

        // ---- alias table ----
        for (int k = 0; k < 13; k++) begin
            apb_write(vecs[k].addr, vecs[k].wdata);
            exp_oen = ~vecs[k].exp_dir;
            check("tbl_dout", 32'(dout), 32'(vecs[k].exp_out));
            check("tbl_oen", 32'(oen), 32'(exp_oen));
            peek(vecs[k].addr, rd);
            check("tbl_read", rd, 32'(vecs[k].exp_rd));
            peek(32'h0C, rd);
            check("tbl_imask", rd, 32'(vecs[k].exp_imask));
        end
        apb_write(32'h0C, 32'h00);
        apb_write(32'h08, 32'h00);
        apb_write(32'h18, 32'hFF);

        // ---- debounce: bypass latency, glitch rejection, qualified pulse ----
        apb_write(32'h1C, 32'h00);
        din = 8'hA5;
        repeat (2) @(negedge clk);
        peek(32'h00, rd); check("data_lat2", rd, 32'h00);
        @(negedge clk);
        peek(32'h00, rd); check("data_lat3", rd, 32'hA5);
        apb_write(32'h1C, 32'h04);
        din = 8'hA4;
        repeat (3) @(negedge clk);
        din = 8'hA5;
        repeat (8) @(negedge clk);
        peek(32'h00, rd); check("glitch3", rd, 32'hA5);
        din = 8'hA4;
        repeat (5) @(negedge clk);
        peek(32'h00, rd); check("pulse_5", rd, 32'hA5);
        @(negedge clk);
        peek(32'h00, rd); check("pulse_6", rd, 32'hA4);
        din = 8'hA5;
        repeat (8) @(negedge clk);
        peek(32'h00, rd); check("pulse_back", rd, 32'hA5);
        apb_write(32'h1C, 32'h00);

        // ---- rising-edge interrupt and W1C ----
        din = 8'h00;
        repeat (5) @(negedge clk);
        apb_write(32'h14, 32'h01);
        apb_write(32'h10, 32'h01);
        apb_write(32'h0C, 32'h01);
        apb_write(32'h18, 32'hFF);
        din = 8'h01;
        repeat (4) @(negedge clk);
        peek(32'h18, rd); check("edge_flag", rd, 32'h01);
        check("pirq_lag", 32'(pirq), 32'h0);
        @(negedge clk);
        check("pirq_rise", 32'(pirq), 32'h1);
        apb_write(32'h18, 32'h01);
        peek(32'h18, rd); check("w1c_flag", rd, 32'h00);
        check("pirq_hold", 32'(pirq), 32'h1);
        @(negedge clk);
        check("pirq_fall", 32'(pirq), 32'h0);
        din = 8'h00;
        repeat (6) @(negedge clk);
        peek(32'h18, rd); check("fall_noflag", rd, 32'h00);
        check("fall_nopirq", 32'(pirq), 32'h0);

        // ---- level interrupt: set wins over W1C ----
        apb_write(32'h0C, 32'h02);
        apb_write(32'h10, 32'h03);
        apb_write(32'h14, 32'h00);
        apb_write(32'h18, 32'h02);
        peek(32'h18, rd); check("lvl_clear0", rd, 32'h00);
        din = 8'h02;
        repeat (6) @(negedge clk);
        peek(32'h18, rd); check("lvl_flag", rd, 32'h02);
        check("lvl_pirq", 32'(pirq), 32'h1);
        apb_write(32'h18, 32'h02);
        peek(32'h18, rd); check("lvl_w1c_set", rd, 32'h02);
        @(negedge clk);
        check("lvl_pirq_kept", 32'(pirq), 32'h1);
        din = 8'h00;
        repeat (6) @(negedge clk);
        apb_write(32'h18, 32'h02);
        peek(32'h18, rd); check("lvl_clr", rd, 32'h00);
        @(negedge clk);
        check("lvl_pirq_fall", 32'(pirq), 32'h0);

        // ---- reset during an OUT write ----
        apb_write(32'h04, 32'h55);
        check("pre_rst_dout", 32'(dout), 32'h55);
        din = 8'h02;
        repeat (6) @(negedge clk);
        check("pre_rst_pirq", 32'(pirq), 32'h1);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h04; pwdata = 32'hAA;
        @(negedge clk);
        penable = 1'b1; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        check("midrst_dout", 32'(dout), 32'h00);
        check("midrst_oen", 32'(oen), 32'hFF);
        check("midrst_pirq", 32'(pirq), 32'h0);
        peek(32'h18, rd); check("midrst_iflag", rd, 32'h00);

        // ---- random pin traffic against the model ----
        run_random(8'd0, 300);
        run_random(8'd3, 300);
        run_random(8'(1 + $urandom_range(0, 5)), 300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb_gpio_irq.md
Name: apb_gpio_irq

Overview:
- Parametrised next-generation APB GPIO port, NBITS pins (1..32).
- Input path: 2-FF synchroniser, then programmable per-pin debounce filter.
- Output path: direction register plus OUT register; OUT, DIR and IMASK each have OR/AND/XOR alias addresses.
- Interrupts: per-pin edge or level detection with polarity select, sticky W1C flags, one aggregated interrupt line. Sits on the peripheral APB bus beside the existing GPIO.

Parameters:
- NBITS, 8, number of pins; unused upper bits of all registers read 0 and ignore writes.
- OEPOL, 0, output-enable polarity: 1 → gpioo_oen = DIR; 0 → gpioo_oen = ~DIR.
- DBW, 8, width of the debounce threshold register and of each per-pin counter.
- OUT_RST, 0, reset value of OUT[NBITS-1:0].

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- apbi_psel  in  1  APB select.
- apbi_penable  in  1  APB enable.
- apbi_paddr  in  32  APB address; only [7:2] decoded.
- apbi_pwrite  in  1  APB write strobe.
- apbi_pwdata  in  32  APB write data.
- apbo_prdata  out  32  APB read data, combinational, valid in access phase.
- apbo_pirq  out  1  aggregated interrupt, registered.
- gpioi_din  in  NBITS  pad inputs, asynchronous.
- gpioo_dout  out  NBITS  pad output data (= OUT).
- gpioo_oen  out  NBITS  pad output enable per OEPOL.

Behaviour:
- Reset: rst is synchronous and active-high; clock is clk.
  - Reset values: OUT = OUT_RST, DIR = 0, IMASK = 0, POL = 0, EDGE = 0, IFLAG = 0, DBTH = 0.
  - Synchroniser, filter state and counters clear to 0; apbo_pirq = 0.
  - gpioo_oen resets to all-0 if OEPOL = 1, all-1 if OEPOL = 0 (all pins inputs).
  - Reset mid-transfer aborts the transfer; no register update occurs.
- APB: no wait states. Write commits when psel & penable & pwrite; new value is visible on outputs the next cycle. Undecoded addresses read 0, writes ignored.
- Register map:
  - 0x00 DATA (RO, filtered input)
  - 0x04 OUT, 0x08 DIR, 0x0C IMASK
  - 0x10 POL (1 = rising/high, 0 = falling/low)
  - 0x14 EDGE (1 = edge, 0 = level)
  - 0x18 IFLAG (read flags, write-1-to-clear)
  - 0x1C DBTH (DBW bits)
  - 0x54/0x58/0x5C: OR into OUT/DIR/IMASK
  - 0x64/0x68/0x6C: AND into OUT/DIR/IMASK
  - 0x74/0x78/0x7C: XOR into OUT/DIR/IMASK
  - Alias addresses read back the base register.
- Synchroniser: 2 flops per pin (s2 = synchronised input).
- Debounce, per pin, filt register:
  - DBTH = 0: filt <= s2 every cycle (bypass). Total input latency is 3 cycles pin→DATA.
  - DBTH > 0, s2 == filt: counter <= 0.
  - DBTH > 0, s2 != filt: counter increments; when counter == DBTH - 1, filt <= s2 and counter <= 0. A pin change must hold DBTH cycles after synchronisation.
  - Counter saturates; it never wraps.
  - A DBTH write resets all counters to 0 the next cycle.
- Event per pin (uses filt and filt_d, its one-cycle delay):
  - EDGE = 1: POL = 1 → filt & ~filt_d; POL = 0 → ~filt & filt_d.
  - EDGE = 0: filt == POL, asserted every cycle the level holds.
- IFLAG[i] <= (IFLAG[i] & ~w1c[i]) | (event[i] & IMASK[i]). Set wins over a simultaneous clear.
- apbo_pirq <= |IFLAG, registered: rises one cycle after a flag sets, falls one cycle after the last flag clears.
- Pins in output mode still feed DATA and can raise events (pad loopback).

Test Plan:
- DIR = 0xFF; write OUT = 0x00..0xFF → gpioo_dout equals the value one cycle later; gpioo_oen = 0x00 (OEPOL = 0).
- OUT = 0xF0, then OR 0x0F @0x54 → 0xFF; AND 0x3C @0x64 → 0x3C; XOR 0xFF @0x74 → 0xC3; read 0x04 returns 0xC3.
- DBTH = 0, drive din = 0xA5 → DATA = 0xA5 after 3 cycles; DBTH = 4, 3-cycle glitch on bit0 → DATA unchanged; 6-cycle pulse → bit0 changes.
- IMASK = 0x01, EDGE = 0x01, POL = 0x01, rising din[0] → IFLAG = 0x01 and apbo_pirq = 1; write IFLAG 0x01 → pirq = 0 two cycles later; falling edge → no flag.
- Level mode (EDGE = 0, POL = 1, din[1] held high) → W1C in the same cycle as the event leaves IFLAG[1] = 1.
- Assert rst during an APB write to 0x04 → OUT = OUT_RST, IFLAG = 0, pirq = 0 next cycle.
